exec_queue: RTL and testbench

Parametrised execution queue that buffers issued instruction packets between dispatch and an execution unit in the superscalar pipeline. It generalises the fixed 4-entry execution FIFO: any power-of-two depth, arbitrary width, first-word-fall-through read, occupancy count, almost-full back-pressure, a simultaneous read/write when full, and sticky overflow/underflow flags. A synchronous flush on branch mispredict empties it in one cycle.

---
 rtl/exec_queue_pkg.sv | 15 +
 rtl/exec_queue_if.sv | 36 +++
 rtl/exec_queue_ptr.sv | 34 +++
 rtl/exec_queue.sv | 118 +++++++++++
 tb/tb_exec_queue.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/exec_queue_pkg.sv
// Shared types, defaults and helpers for the execution queue between dispatch and execute.
package exec_queue_pkg;

  localparam int DEF_DEPTH      = 4;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_AF_MARGIN  = 1;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [DEF_DATA_WIDTH-1:0] exec_pkt_t;

endpackage

// File: rtl/exec_queue_if.sv
// Dispatch/execute-side signal bundle of the execution queue; master drives requests, slave is the queue.
interface exec_queue_if
  import exec_queue_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  localparam int CNT_W = ptr_w(DEPTH);

  logic                  i_flush;
  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_rd_en;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_almost_full;
  logic [CNT_W-1:0]      o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_flush, i_wr_en, i_data, i_rd_en,
    input  o_data, o_valid, o_empty, o_full, o_almost_full, o_count,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_wr_en, i_data, i_rd_en,
    output o_data, o_valid, o_empty, o_full, o_almost_full, o_count,
           o_overflow, o_underflow
  );

endinterface

// File: rtl/exec_queue_ptr.sv
// Wrapping queue pointer: clears on i_clr, otherwise steps by one on i_inc with natural rollover.
module exec_queue_ptr #(
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/exec_queue.sv
// First-word-fall-through execution queue with occupancy, almost-full and sticky error flags.
// Optional same-cycle empty bypass is enabled by defining EXEC_QUEUE_BYPASS_EN.
module exec_queue
  import exec_queue_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AF_MARGIN  = DEF_AF_MARGIN
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  exec_queue_if.slave   bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("exec_queue: DEPTH must be a power of two and at least 2");
  end
  if ((AF_MARGIN < 0) || (AF_MARGIN >= DEPTH)) begin : g_bad_margin
    $error("exec_queue: AF_MARGIN must lie in 0..DEPTH-1");
  end

  logic [PW-1:0]         wp_q;
  logic [PW-1:0]         rp_q;
  logic [PW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  empty;
  logic                  full;
  logic                  byp_hit;
  logic                  byp_consume;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign count = wp_q - rp_q;

`ifdef EXEC_QUEUE_BYPASS_EN
  assign byp_hit = empty & bus.i_wr_en;
`else
  assign byp_hit = 1'b0;
`endif

  // A bypassed packet that is also read leaves the queue untouched.
  assign byp_consume = byp_hit & bus.i_rd_en;
  assign pop_acc     = bus.i_rd_en & ~empty & ~bus.i_flush;
  assign push_acc    = bus.i_wr_en & (~full | pop_acc) & ~byp_consume & ~bus.i_flush;
  assign ovf_set     = bus.i_wr_en & full & ~pop_acc;
  assign unf_set     = bus.i_rd_en & empty & ~byp_hit;

  exec_queue_ptr #(.WIDTH(PW)) u_wp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (bus.i_flush),
    .i_inc   (push_acc),
    .o_ptr   (wp_q)
  );

  exec_queue_ptr #(.WIDTH(PW)) u_rp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (bus.i_flush),
    .i_inc   (pop_acc),
    .o_ptr   (rp_q)
  );

  always_ff @(posedge i_clk) begin
    if (push_acc) begin
      mem_q[wp_q[AW-1:0]] <= bus.i_data;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.i_flush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (ovf_set) ovf_d = 1'b1;
      if (unf_set) unf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stale memory never leaks: the head is forced to zero while empty.
`ifdef EXEC_QUEUE_BYPASS_EN
  assign bus.o_data  = byp_hit ? bus.i_data
                     : (empty ? '0 : mem_q[rp_q[AW-1:0]]);
  assign bus.o_valid = ~empty | byp_hit;
`else
  assign bus.o_data  = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign bus.o_valid = ~empty;
`endif

  assign bus.o_empty       = empty;
  assign bus.o_full        = full;
  assign bus.o_count       = count;
  assign bus.o_almost_full = (count >= PW'(DEPTH - AF_MARGIN));
  assign bus.o_overflow    = ovf_q;
  assign bus.o_underflow   = unf_q;

endmodule

// File: tb/tb_exec_queue.sv
// Directed scoreboard bench for exec_queue (DEPTH=4, DATA_WIDTH=8, AF_MARGIN=1).
module tb_exec_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AFM   = 1;
`ifdef EXEC_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  exec_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_MARGIN(AFM)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [DW-1:0] sb[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int c;
    c = sb.size();
    chk({tag, "/count"}, 32'(bus.o_count), c);
    chk({tag, "/empty"}, 32'(bus.o_empty), (c == 0));
    chk({tag, "/full"},  32'(bus.o_full),  (c == DEPTH));
    chk({tag, "/afull"}, 32'(bus.o_almost_full), (c >= DEPTH - AFM));
    chk({tag, "/valid"}, 32'(bus.o_valid), (c != 0));
    chk({tag, "/data"},  32'(bus.o_data),  (c != 0) ? 32'(sb[0]) : 32'h0);
    chk({tag, "/ovf"},   32'(bus.o_overflow),  m_ovf);
    chk({tag, "/unf"},   32'(bus.o_underflow), m_unf);
  endtask

  // One clock of stimulus; scoreboard is updated on the edge, outputs checked after it.
  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit fl,
                      input string tag);
    bit byp, pop, push;
    bus.i_wr_en = wr;
    bus.i_data  = d;
    bus.i_rd_en = rd;
    bus.i_flush = fl;
    #1;
    byp = BYP && (sb.size() == 0) && wr;
    pop = rd && (sb.size() != 0) && !fl;
    chk({tag, "/pre_valid"}, 32'(bus.o_valid), (sb.size() != 0) || byp);
    if (byp) chk({tag, "/pre_byp_data"}, 32'(bus.o_data), 32'(d));
    else if (pop) chk({tag, "/pop_data"}, 32'(bus.o_data), 32'(sb[0]));
    @(posedge clk);
    if (fl) begin
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      push = wr && ((sb.size() < DEPTH) || pop) && !(byp && rd);
      if (wr && !push && !(byp && rd)) m_ovf = 1'b1;
      if (rd && (sb.size() == 0) && !byp) m_unf = 1'b1;
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(d);
    end
    #1;
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_data  = '0;
    #1;
    check_state(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pop_exp [4];
    int            max_cnt;
    pop_exp = '{8'h22, 8'h33, 8'h44, 8'h66};

    rst_n       = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_data  = '0;
    #2;
    check_state("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // Fill to full
    step(1, 8'h11, 0, 0, "push1");
    chk("push1_cnt", 32'(bus.o_count), 1);
    chk("push1_af", 32'(bus.o_almost_full), 0);
    step(1, 8'h22, 0, 0, "push2");
    chk("push2_cnt", 32'(bus.o_count), 2);
    step(1, 8'h33, 0, 0, "push3");
    chk("push3_af", 32'(bus.o_almost_full), 1);
    chk("push3_full", 32'(bus.o_full), 0);
    step(1, 8'h44, 0, 0, "push4");
    chk("push4_full", 32'(bus.o_full), 1);
    chk("push4_head", 32'(bus.o_data), 32'h11);

    // Overflow, then simultaneous push/pop at full
    step(1, 8'h55, 0, 0, "ovf");
    chk("ovf_flag", 32'(bus.o_overflow), 1);
    chk("ovf_cnt", 32'(bus.o_count), 4);
    step(1, 8'h66, 1, 0, "rw_full");
    chk("rw_full_cnt", 32'(bus.o_count), 4);
    chk("rw_full_head", 32'(bus.o_data), 32'h22);

    // Drain
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(bus.o_data), 32'(pop_exp[i]));
      step(0, '0, 1, 0, "drain");
    end
    chk("drain_empty", 32'(bus.o_empty), 1);
    step(0, '0, 1, 0, "extra_pop");
    chk("unf_flag", 32'(bus.o_underflow), 1);
    chk("unf_data", 32'(bus.o_data), 0);

    // Pointer wrap
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, DW'(8'hB0 + i), 0, 0, "wrap_push");
      if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
      step(0, '0, 1, 0, "wrap_pop");
      if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
    end
    chk("wrap_max_cnt", 32'(max_cnt), 1);

    // Flush overrides a same-cycle push
    step(1, 8'h71, 0, 0, "pre_flush");
    step(1, 8'h72, 0, 0, "pre_flush");
    step(1, 8'h73, 0, 0, "pre_flush");
    chk("pre_flush_cnt", 32'(bus.o_count), 3);
    step(1, 8'h74, 0, 1, "flush");
    chk("flush_cnt", 32'(bus.o_count), 0);
    chk("flush_empty", 32'(bus.o_empty), 1);
    chk("flush_ovf", 32'(bus.o_overflow), 0);
    chk("flush_unf", 32'(bus.o_underflow), 0);
    step(0, '0, 0, 0, "post_flush");

    // Write and read together while empty
    step(1, 8'hA5, 1, 0, "byp");
`ifdef EXEC_QUEUE_BYPASS_EN
    chk("byp_cnt", 32'(bus.o_count), 0);
    chk("byp_unf", 32'(bus.o_underflow), 0);
`else
    chk("nobyp_cnt", 32'(bus.o_count), 1);
    chk("nobyp_unf", 32'(bus.o_underflow), 1);
    chk("nobyp_data", 32'(bus.o_data), 32'hA5);
    step(0, '0, 1, 0, "nobyp_drain");
`endif

    // Asynchronous reset mid-operation
    step(1, 8'hC1, 0, 0, "pre_rst");
    step(1, 8'hC2, 0, 0, "pre_rst");
    #1 rst_n = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_state("mid_rst");
    #1 rst_n = 1'b1;
    #1;
    step(1, 8'h5A, 0, 0, "post_rst");
    chk("post_rst_cnt", 32'(bus.o_count), 1);
    chk("post_rst_data", 32'(bus.o_data), 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
